// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial link: FSM state encoding, line levels
// and default frame parameters. The receive side is meant to import the
// same package so both ends agree on framing.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  localparam int DATA_W_DEF       = 8;
  localparam int CLKS_PER_BIT_DEF = 4;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// bit_timer: down-counter that times one bit period on the serial line.
// While clr is high the counter is parked at CLKS_PER_BIT-1, so the first
// period after clr drops is a full bit. tick pulses for one cycle in the
// last cycle of every bit period, and the counter reloads on that cycle.
// With CLKS_PER_BIT=1 the counter is constant 0 and tick is ~clr.
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset (clears the counter)
//   clr    in   hold the timer at the start of a bit period
//   tick   out  last cycle of the current bit period
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || (cnt_q == '0)) begin
      cnt_d = LAST;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = ~clr & (cnt_q == '0);

endmodule

// File: rtl/serial_tx.sv
// serial_tx: asynchronous serial transmitter. A word accepted over the
// valid/ready handshake is sent as start bit, DATA_W data bits LSB first,
// stop bit, each held CLKS_PER_BIT cycles. All outputs are registered and
// are computed from the next state, so tx moves only on bit boundaries.
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   tx_data   in   word to send, sampled on the handshake edge only
//   tx_valid  in   tx_data is valid
//   tx_ready  out  a word can be accepted this cycle (IDLE)
//   tx        out  serial line, idle/stop high, start low
//   busy      out  a frame is on the line
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              tx_ready_q, tx_ready_d;
  logic              tick;

  // Timer is held in IDLE so the start bit always gets a full period.
  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == IDLE),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;

    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready_q) begin
          shreg_d  = tx_data;
          bitcnt_d = '0;
          state_d  = START;
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bitcnt_q == LAST_BIT) begin
            bitcnt_d = '0;
            state_d  = STOP;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs follow the state being entered so they are registered
    // without adding a cycle of latency.
    case (state_d)
      START:   tx_d = START_BIT;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = LINE_IDLE;
    endcase
    busy_d     = (state_d != IDLE);
    tx_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      tx_q       <= LINE_IDLE;
      busy_q     <= 1'b0;
      tx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign tx_ready = tx_ready_q;

endmodule

// File: tb/tb_serial_tx.sv
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data_a, tx_data_b;
  logic       tx_valid_a, tx_valid_b;
  logic       tx_ready_a, tx_ready_b;
  logic       tx_a, tx_b;
  logic       busy_a, busy_b;

  always #5 clk = ~clk;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .tx(tx_a), .busy(busy_a)
  );

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .tx(tx_b), .busy(busy_b)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int hs_cnt_a  = 0;
  int hs_prev_a = 0;
  int hs_last_a = 0;

  // Handshake log for dut_a (pre-edge values of valid/ready).
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n === 1'b1 && tx_valid_a === 1'b1 && tx_ready_a === 1'b1) begin
      hs_prev_a = hs_last_a;
      hs_last_a = cyc;
      hs_cnt_a  = hs_cnt_a + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic s_tx(input int sel);
    return (sel != 0) ? tx_b : tx_a;
  endfunction

  function automatic logic s_busy(input int sel);
    return (sel != 0) ? busy_b : busy_a;
  endfunction

  function automatic logic s_ready(input int sel);
    return (sel != 0) ? tx_ready_b : tx_ready_a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word, wait for ready, let the handshake edge pass. Returns in
  // the first cycle of the start bit.
  task automatic send(input int sel, input logic [7:0] d, input bit keep_valid);
    int k = 0;
    if (sel != 0) begin tx_data_b = d; tx_valid_b = 1'b1; end
    else          begin tx_data_a = d; tx_valid_a = 1'b1; end
    while (s_ready(sel) !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    chk("ready_wait", 32'(k < 200), 32'd1);
    chk("tx_idle_pre", 32'(s_tx(sel)), 32'd1);
    step();
    if (!keep_valid) begin
      if (sel != 0) tx_valid_b = 1'b0;
      else          tx_valid_a = 1'b0;
    end
  endtask

  // seq[0] is the first bit on the line (start), seq[9] the stop bit.
  task automatic frame_chk(input int sel, input logic [9:0] seq, input int cpb,
                           input bit disturb, input string tag);
    int nb = 0;
    for (int i = 0; i < 10 * cpb; i++) begin
      chk($sformatf("%s_bit%0d_c%0d", tag, i / cpb, i % cpb), 32'(s_tx(sel)), 32'(seq[i / cpb]));
      if (s_busy(sel) === 1'b1) nb++;
      if (disturb && i == 6) begin tx_data_a = 8'hC3; tx_valid_a = 1'b1; end
      if (disturb && i == 7) tx_valid_a = 1'b0;
      step();
    end
    chk({tag, "_busy_len"}, 32'(nb), 32'(10 * cpb));
    chk({tag, "_after_tx"}, 32'(s_tx(sel)), 32'd1);
    chk({tag, "_after_busy"}, 32'(s_busy(sel)), 32'd0);
    chk({tag, "_after_ready"}, 32'(s_ready(sel)), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    int lows;
    rst_n      = 1'b0;
    tx_valid_a = 1'b1;
    tx_valid_b = 1'b0;
    tx_data_a  = 8'h5A;
    tx_data_b  = 8'h00;

    // Reset held 3 cycles with tx_valid high.
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_tx_%0d", i), 32'(tx_a), 32'd1);
      chk($sformatf("rst_ready_%0d", i), 32'(tx_ready_a), 32'd0);
      chk($sformatf("rst_busy_%0d", i), 32'(busy_a), 32'd0);
    end
    rst_n = 1'b1;
    step();
    chk("rel_ready", 32'(tx_ready_a), 32'd1);
    chk("rel_tx", 32'(tx_a), 32'd1);
    tx_valid_a = 1'b0;
    chk("rel_no_hs", 32'(hs_cnt_a), 32'd0);
    step();

    // 0xA5: 0,1,0,1,0,0,1,0,1,1
    send(0, 8'hA5, 1'b0);
    frame_chk(0, 10'b1101001010, 4, 1'b0, "a5");

    // Back-to-back 0x00 then 0xFF with valid held high.
    hs0 = hs_cnt_a;
    send(0, 8'h00, 1'b1);
    tx_data_a = 8'hFF;
    frame_chk(0, 10'b1000000000, 4, 1'b0, "b2b_00");
    step();
    tx_valid_a = 1'b0;
    frame_chk(0, 10'b1111111110, 4, 1'b0, "b2b_ff");
    chk("b2b_spacing", 32'(hs_last_a - hs_prev_a), 32'd41);
    chk("b2b_count", 32'(hs_cnt_a - hs0), 32'd2);

    // 0x3C with tx_data/tx_valid disturbed mid-frame.
    hs0 = hs_cnt_a;
    send(0, 8'h3C, 1'b0);
    frame_chk(0, 10'b1001111000, 4, 1'b1, "ign_3c");
    lows = 0;
    for (int i = 0; i < 15; i++) begin
      if (tx_a !== 1'b1) lows++;
      step();
    end
    chk("ign_quiet", 32'(lows), 32'd0);
    chk("ign_hs_count", 32'(hs_cnt_a - hs0), 32'd1);

    // 0x81 with reset during data bit 2 (frame cycles 12..15).
    send(0, 8'h81, 1'b0);
    repeat (13) step();
    chk("mid_pre_tx", 32'(tx_a), 32'd0);
    rst_n = 1'b0;
    step();
    chk("mid_rst_tx", 32'(tx_a), 32'd1);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_ready", 32'(tx_ready_a), 32'd0);
    rst_n = 1'b1;
    step();
    chk("mid_rel_ready", 32'(tx_ready_a), 32'd1);
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx_a !== 1'b1 || busy_a !== 1'b0) lows++;
      step();
    end
    chk("mid_quiet", 32'(lows), 32'd0);

    // CLKS_PER_BIT=1, 0x01: 0,1,0,0,0,0,0,0,0,1
    send(1, 8'h01, 1'b0);
    frame_chk(1, 10'b1000000010, 1, 1'b0, "c1_01");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
